// File: rtl/aes_pkg.sv
// Shared AES constants, types and word helpers used by the key schedule
// and the round datapath.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;

    typedef logic [31:0] aes_word_t;

    // Round constants for the key schedule. This is a fixed table rather
    // than an xtime chain, so no arithmetic sits on the Rcon path.
    localparam logic [7:0] AES_RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, one byte out. Shared by the key
// schedule (SubWord) and the cipher rounds (SubBytes).
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: accepts one cipher key and emits the
// round keys K0..K10 on consecutive cycles, tagged with their round index.
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int DATA_LEN   = 128,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid_in,
    input  logic [DATA_LEN-1:0] key_in,
    output logic                ready,
    output logic                round_key_valid,
    output logic [DATA_LEN-1:0] round_key,
    output logic [3:0]          round_idx,
    output logic                done
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t    state;
    aes_word_t w0, w1, w2, w3;
    aes_word_t rot_w3, sub_w3, t_word;
    aes_word_t n0, n1, n2, n3;
    logic [7:0] rcon;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign rot_w3 = rot_word(w3);

    // SubWord: four parallel S-box lookups on the rotated last word
    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_w3[8*b +: 8])
        );
    end

    // Round counter doubles as the Rcon index; guard the unused index 10
    always_comb begin
        rcon = 8'h00;
        if (round_idx < 4'd10)
            rcon = AES_RCON[round_idx];
    end

    assign t_word = sub_w3 ^ {rcon, 24'h0};
    assign n0 = w0 ^ t_word;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign ready = (state == IDLE);

    // Control FSM and round-key register; every output is registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            round_key       <= '0;
            round_idx       <= 4'd0;
            round_key_valid <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    round_key_valid <= 1'b0;
                    done            <= 1'b0;
                    if (key_valid_in) begin
                        round_key       <= key_in;
                        round_idx       <= 4'd0;
                        round_key_valid <= 1'b1;
                        state           <= EXPAND;
                    end
                end
                EXPAND: begin
                    round_key       <= {n0, n1, n2, n3};
                    round_idx       <= round_idx + 4'd1;
                    round_key_valid <= 1'b1;
                    done            <= 1'b0;
                    if (round_idx == 4'(NUM_ROUNDS - 1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state           <= IDLE;
                    round_key_valid <= 1'b0;
                    done            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion. The reference model builds the
// S-box from GF(2^8) inversion plus the affine map and runs the textbook
// 44-word schedule with Rcon generated by xtime.
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         key_valid_in = 1'b0;
    logic [127:0] key_in = '0;
    logic         ready;
    logic         round_key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] model_keys [0:10];

    aes_key_expansion #(.DATA_LEN(128), .NUM_ROUNDS(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .key_valid_in    (key_valid_in),
        .key_in          (key_in),
        .ready           (ready),
        .round_key_valid (round_key_valid),
        .round_key       (round_key),
        .round_idx       (round_idx),
        .done            (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]],
                       sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (round_key_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b done=%b required 0 0", round_key_valid, done);
        end
        vectors++;
        if (round_key !== 128'h0 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: key=%h idx=%0d required 0 0", round_key, round_idx);
        end
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", ready);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || round_key_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b valid=%b required 1 0", ready, round_key_valid);
        end
    endtask

    task automatic test_known(input string name, input logic [127:0] key,
                              input logic [127:0] exp1, input logic [127:0] exp10);
        model_expand(key);
        @(negedge clk);
        key_in = key;
        key_valid_in = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0) key_valid_in = 1'b0;
            vectors++;
            if (round_key_valid !== 1'b1 || round_idx !== 4'(c) || round_key !== model_keys[c]) begin
                errors++;
                $display("FAIL %s_k%0d: valid=%b idx=%0d key=%h required 1 %0d %h",
                         name, c, round_key_valid, round_idx, round_key, c, model_keys[c]);
            end
            vectors++;
            if (done !== (c == 10) || ready !== (c == 10)) begin
                errors++;
                $display("FAIL %s_ctl%0d: done=%b ready=%b required %b %b",
                         name, c, done, ready, (c == 10), (c == 10));
            end
            if (c == 0 && round_key !== key) begin
                vectors++;
                errors++;
                $display("FAIL %s_idx0: got %h required %h", name, round_key, key);
            end
            if (c == 1) begin
                vectors++;
                if (round_key !== exp1) begin
                    errors++;
                    $display("FAIL %s_idx1: got %h required %h", name, round_key, exp1);
                end
            end
            if (c == 10) begin
                vectors++;
                if (round_key !== exp10 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_idx10: got %h done=%b required %h done=1",
                             name, round_key, done, exp10);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (round_key_valid !== 1'b0 || done !== 1'b0 || round_key !== exp10) begin
            errors++;
            $display("FAIL %s_hold: valid=%b done=%b key=%h required 0 0 %h",
                     name, round_key_valid, done, round_key, exp10);
        end
    endtask

    task automatic test_random();
        logic [127:0] key;
        for (int n = 0; n < 8; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            key_in = key;
            key_valid_in = 1'b1;
            for (int c = 0; c <= 10; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    key_valid_in = 1'b0;
                    key_in = {$urandom, $urandom, $urandom, $urandom};
                end
                vectors++;
                if (round_key_valid !== 1'b1 || round_idx !== 4'(c) ||
                    round_key !== model_keys[c] || done !== (c == 10)) begin
                    errors++;
                    $display("FAIL rand%0d_k%0d: valid=%b idx=%0d key=%h done=%b required 1 %0d %h %b",
                             n, c, round_key_valid, round_idx, round_key, done, c, model_keys[c], (c == 10));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_keys [0:21];
        int dones;
        model_expand(FIPS_KEY);
        for (int r = 0; r < 11; r++) exp_keys[r] = model_keys[r];
        model_expand(ZERO_KEY);
        for (int r = 0; r < 11; r++) exp_keys[11 + r] = model_keys[r];
        dones = 0;
        key_in = FIPS_KEY;
        key_valid_in = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c == 0) key_in = ZERO_KEY;
            if (c == 11) key_valid_in = 1'b0;
            if (done === 1'b1) dones++;
            vectors++;
            if (round_key_valid !== 1'b1 || round_idx !== 4'(c % 11) || round_key !== exp_keys[c]) begin
                errors++;
                $display("FAIL b2b_c%0d: valid=%b idx=%0d key=%h required 1 %0d %h",
                         c, round_key_valid, round_idx, round_key, c % 11, exp_keys[c]);
            end
        end
        @(negedge clk);
        vectors++;
        if (dones != 2 || round_key_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: dones=%0d valid=%b required 2 0", dones, round_key_valid);
        end
    endtask

    task automatic test_busy_drop();
        int extra;
        model_expand(FIPS_KEY);
        key_in = FIPS_KEY;
        key_valid_in = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            key_valid_in = (c == 2);
            if (c == 2) key_in = ZERO_KEY;
            vectors++;
            if (round_key_valid !== 1'b1 || round_idx !== 4'(c) || round_key !== model_keys[c]) begin
                errors++;
                $display("FAIL drop_k%0d: valid=%b idx=%0d key=%h required 1 %0d %h",
                         c, round_key_valid, round_idx, round_key, c, model_keys[c]);
            end
            if (c == 10) begin
                vectors++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_ready: got %b required 1", ready);
                end
            end
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (round_key_valid !== 1'b0 || done !== 1'b0) extra++;
        end
        vectors++;
        if (extra != 0) begin
            errors++;
            $display("FAIL drop_no_second_burst: %0d active cycles required 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        int stray;
        key_in = FIPS_KEY;
        key_valid_in = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            key_valid_in = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (round_key_valid !== 1'b0 || round_key !== 128'h0 || round_idx !== 4'd0 ||
            ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b key=%h idx=%0d ready=%b done=%b required 0 0 0 1 0",
                     round_key_valid, round_key, round_idx, ready, done);
        end
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (round_key_valid !== 1'b0 || done !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d active cycles required 0", stray);
        end
        test_known("midrst_fips", FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    endtask

    task automatic test_reset_with_key();
        @(negedge clk);
        reset = 1'b0;
        key_in = FIPS_KEY;
        key_valid_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        key_valid_in = 1'b0;
        vectors++;
        if (round_key_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rstkey_accept: valid=%b ready=%b required 0 1", round_key_valid, ready);
        end
        @(negedge clk);
        vectors++;
        if (round_key_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rstkey_idle: valid=%b ready=%b required 0 1", round_key_valid, ready);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_known("fips", FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        test_known("zero", ZERO_KEY, 128'h62636363626363636263636362636363,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        test_random();
        test_back_to_back();
        test_busy_drop();
        test_mid_reset();
        test_reset_with_key();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expansion.md
# aes_key_expansion

Iterative AES-128 key schedule that accepts one cipher key and emits the 11 round keys, one per clock, with a valid strobe and round index. It sits directly upstream of the round pipeline and drives each round's `sub_key` / `key_valid_in` inputs. Downstream logic latches or routes keys by `round_idx`.

## Interface

Parameters:

- `DATA_LEN`, 128: key and round-key width. Only 128 is supported.
- `NUM_ROUNDS`, 10: index of the last round key emitted. Keys 0..`NUM_ROUNDS` are produced.

Ports:

- `clk`, in, 1: system clock. There is one clock. All logic is rising-edge.
- `reset`, in, 1: synchronous, active-low reset.
- `key_valid_in`, in, 1: cipher key present on `key_in`.
- `key_in`, in, `DATA_LEN`: cipher key. Bits [127:96] are w0; bits [127:120] are key byte 0.
- `ready`, out, 1: block can accept a key. Equals (state == IDLE).
- `round_key_valid`, out, 1: `round_key` and `round_idx` are valid this cycle.
- `round_key`, out, `DATA_LEN`: round key Ki. Same word and byte order as `key_in`.
- `round_idx`, out, 4: index i of the current `round_key`, range 0..`NUM_ROUNDS`.
- `done`, out, 1: single-cycle pulse, coincident with the key at `round_idx` = `NUM_ROUNDS`.

## Operation

- The state machine has two states, IDLE and EXPAND.
- **IDLE → EXPAND**: at an edge where `reset`=1, `key_valid_in`=1 and `ready`=1.
  - On that edge: `round_key` ← `key_in` (K0), `round_idx` ← 0, `round_key_valid` ← 1, Rcon index ← 0.
- **In EXPAND**, each edge computes K(i+1) from Ki = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {Rcon[i], 24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Outputs: `round_idx` ← i+1, `round_key_valid` ← 1.
- RotWord rotates bytes left by one: {b1,b2,b3,b0}.
- SubWord applies the AES S-box to each byte.
- Rcon sequence is 01,02,04,08,10,20,40,80,1b,36. It is a constant table, not computed by xtime.
- **EXPAND → IDLE**: on the edge that loads K`NUM_ROUNDS`; `done` ← 1 on that same edge.
- On any edge that does not load a key, `round_key_valid` ← 0 and `done` ← 0. `round_key` and `round_idx` hold their last values.
- `key_valid_in` is ignored while `ready`=0. There is no queuing: a key offered while busy is dropped, and the source must hold it until `ready`.
- No stalls are possible: once started, the 11 keys are emitted on 11 consecutive cycles.

## Timing

- **Reset** (edge with `reset`=0) forces state IDLE and:
  - `round_key` = 0, `round_idx` = 0, `round_key_valid` = 0, `done` = 0, Rcon index = 0.
  - `ready` = 1 from the cycle after the reset edge.
- **Latency**: key accepted at edge E0. Ki is visible during the cycle following edge Ei, for i = 0..10. K10 and `done` are visible after E10.
- **Back-to-back**: `ready` is high in the cycle after E10. A key accepted at E11 yields its K0 after E11, giving a gap-free stream of 11-key bursts.
- **Reset mid-expansion**: aborts immediately. No further valid keys are emitted and no `done` pulse occurs.
- **Reset coincident with `key_valid_in`**: reset wins and the key is not accepted.
- **Combinational path**: the S-box is on the path from the `round_key` register back to itself only. There is no combinational path from inputs to outputs except `ready`, which is state-only.

## Structure

- Shared package `aes_pkg` holds:
  - `AES_RCON[0:9]` constant array
  - `AES_NUM_ROUNDS` = 10
  - a 32-bit `aes_word_t` typedef
  - `rot_word` function
- Sub-module `aes_sbox`: a combinational 8-bit in / 8-bit out lookup, instantiated 4× for SubWord. The same module serves the SubBytes stage.
- The rest is one FSM with a 4-bit round counter, which doubles as the Rcon index.

## Test plan

- **FIPS-197 key** 2b7e151628aed2a6abf7158809cf4f3c:
  - idx0 = key
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done`=1 in the same cycle
- **All-zero key**:
  - idx1 = 62636363626363636263636362636363
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e
- **Back-to-back**: FIPS key at E0, then zero key held until `ready`.
  - 22 consecutive valid cycles, idx running 0..10, 0..10.
  - Exactly two `done` pulses.
- **Busy drop**: pulse `key_valid_in` with the zero key at E3 of a FIPS expansion.
  - FIPS keys are unaffected.
  - `ready` rises after E10.
  - No second burst follows.
- **Mid-run reset**: drive `reset`=0 at E5.
  - Next cycle: `round_key_valid`=0, `round_key`=0, `round_idx`=0, `ready`=1.
  - No `done` pulse.
  - A fresh FIPS key afterwards produces correct K0..K10.
- **Reset with key**: `reset`=0 and `key_valid_in`=1 on the same edge.
  - No valid output on the following cycle.
  - State remains IDLE.
